// File: rtl/pe_row_sequencer.sv
// Packs 32 serial WIDTH-bit operands into a row bus and sweeps the mux32 select over it.
// Define SEL_DESCEND_EN to stream 31 down to 0 instead of 0 up to 31.
module pe_row_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  start,
    input  logic [3:0]            rep_num,
    input  logic                  stall,
    output logic [WIDTH*32-1:0]   row_bus,
    output logic [4:0]            sel,
    output logic                  sel_valid,
    output logic                  busy,
    output logic                  done
);

`ifdef SEL_DESCEND_EN
    localparam logic [4:0] SEL_FIRST = 5'd31;
    localparam logic [4:0] SEL_LAST  = 5'd0;
`else
    localparam logic [4:0] SEL_FIRST = 5'd0;
    localparam logic [4:0] SEL_LAST  = 5'd31;
`endif

    typedef enum logic [1:0] {
        LOAD,
        FULL,
        STREAM
    } state_t;

    state_t      state;
    logic [4:0]  load_cnt;
    logic [3:0]  pass_cnt;
    logic [3:0]  rep_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            row_bus   <= '0;
            sel       <= '0;
            sel_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_cnt  <= '0;
            pass_cnt  <= '0;
            rep_lat   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        // operand k lands in slice 31-k so that mux32 sel=k picks it
                        row_bus[WIDTH*int'(~load_cnt) +: WIDTH] <= in_data;
                        load_cnt <= load_cnt + 5'd1;
                        if (load_cnt == 5'd31) begin
                            state    <= FULL;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (start) begin
                        rep_lat   <= rep_num;
                        pass_cnt  <= '0;
                        sel       <= SEL_FIRST;
                        sel_valid <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        if (sel == SEL_LAST) begin
                            if (pass_cnt == rep_lat) begin
                                state     <= LOAD;
                                done      <= 1'b1;
                                sel_valid <= 1'b0;
                                sel       <= '0;
                                load_cnt  <= '0;
                                in_ready  <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                sel      <= SEL_FIRST;
                                pass_cnt <= pass_cnt + 4'd1;
                            end
                        end else begin
`ifdef SEL_DESCEND_EN
                            sel <= sel - 5'd1;
`else
                            sel <= sel + 5'd1;
`endif
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
